// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage of the ALU. Selects one of NUM_OPS operation-unit
// results (and its {N,Z,C,V} flags) with aluControl, and buffers the selection
// in a 2-entry FIFO so the pipeline can throttle the ALU. Also owns the
// architectural NZCV register, which is written only when an entry tagged
// setFlags leaves the FIFO.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   aluControl [SW-1:0]   operation select (op k = opResults[k*N +: N])
//   opResults             packed unit results, NUM_OPS*N bits
//   opFlags               packed unit flags {N,Z,C,V}, NUM_OPS*4 bits
//   setFlags              entry commits its flags into nzcv when popped
//   inValid / inReady     producer handshake (inReady = not full)
//   outResult, outFlags   head entry contents (hold last head when empty)
//   outValid / outReady   consumer handshake
//   nzcv                  architectural flag register
//   illegalOp             sticky: an accepted aluControl was >= NUM_OPS
//   dbgState              occupancy FSM state (0 EMPTY, 1 ONE, 2 FULL)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Producer side: push = inValid && inReady. Consumer side:
// pop = outValid && outReady. inReady does not look at outReady, so a full
// FIFO never accepts in the same cycle it drains (no pass-through).
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int N       = 32,
  parameter int NUM_OPS = 4,
  localparam int SW     = $clog2(NUM_OPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SW-1:0]        aluControl,
  input  logic [NUM_OPS*N-1:0] opResults,
  input  logic [NUM_OPS*4-1:0] opFlags,
  input  logic                 setFlags,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [N-1:0]         outResult,
  output logic [3:0]           outFlags,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [3:0]           nzcv,
  output logic                 illegalOp,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  // Head is the entry presented on the outputs; tail is only used when FULL.
  logic [N-1:0] head_res, tail_res;
  logic [3:0]   head_flg, tail_flg;
  logic         head_sf,  tail_sf;

  // Selected operation for the current input cycle.
  logic [N-1:0] sel_res;
  logic [3:0]   sel_flg;
  logic         sel_legal;

  logic push, pop;

  // -------------------------------------------------------------------------
  // Operation select. The loop compares against each legal index, so an
  // out-of-range select (possible when NUM_OPS is not a power of two) falls
  // through to the defaults: result 0 with only the Z flag set.
  // -------------------------------------------------------------------------
  always_comb begin
    sel_res   = '0;
    sel_flg   = 4'b0100;
    sel_legal = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (aluControl == SW'(k)) begin
        sel_res   = opResults[k*N +: N];
        sel_flg   = opFlags[k*4 +: 4];
        sel_legal = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign inReady  = !reset && (state != FULL);
  assign outValid = (state != EMPTY);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  // -------------------------------------------------------------------------
  // Occupancy FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: begin
        if (push) state_nx = ONE;
      end
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL: begin
        if (pop) state_nx = ONE;
      end
      default: state_nx = EMPTY;
    endcase
  end

  assign dbgState = state;

  // -------------------------------------------------------------------------
  // Entry storage. A pop from ONE without a push leaves head untouched so the
  // outputs keep showing the last entry while empty.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      head_res <= '0;
      head_flg <= '0;
      head_sf  <= 1'b0;
      tail_res <= '0;
      tail_flg <= '0;
      tail_sf  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_res <= sel_res;
            head_flg <= sel_flg;
            head_sf  <= setFlags;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_res <= sel_res;
            head_flg <= sel_flg;
            head_sf  <= setFlags;
          end else if (push) begin
            tail_res <= sel_res;
            tail_flg <= sel_flg;
            tail_sf  <= setFlags;
          end
        end
        FULL: begin
          if (pop) begin
            head_res <= tail_res;
            head_flg <= tail_flg;
            head_sf  <= tail_sf;
          end
        end
        default: ;
      endcase
    end
  end

  assign outResult = head_res;
  assign outFlags  = head_flg;

  // -------------------------------------------------------------------------
  // Architectural flags and sticky illegal-op indicator. Reset has priority,
  // so a pop coinciding with reset never reaches nzcv.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv      <= 4'b0000;
      illegalOp <= 1'b0;
    end else begin
      if (pop && head_sf) nzcv <= head_flg;
      if (push && !sel_legal) illegalOp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Directed bench for alu_result_stage with N=32, NUM_OPS=3 (so aluControl=3
// is an illegal select). Inputs change 1 ns after the rising edge; outputs
// are sampled there too, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int N       = 32;
  localparam int NUM_OPS = 3;
  localparam int SW      = 2;

  logic                 clk;
  logic                 reset;
  logic [SW-1:0]        aluControl;
  logic [NUM_OPS*N-1:0] opResults;
  logic [NUM_OPS*4-1:0] opFlags;
  logic                 setFlags;
  logic                 inValid;
  logic                 inReady;
  logic [N-1:0]         outResult;
  logic [3:0]           outFlags;
  logic                 outValid;
  logic                 outReady;
  logic [3:0]           nzcv;
  logic                 illegalOp;
  logic [1:0]           dbgState;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  alu_result_stage #(.N(N), .NUM_OPS(NUM_OPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .aluControl (aluControl),
    .opResults  (opResults),
    .opFlags    (opFlags),
    .setFlags   (setFlags),
    .inValid    (inValid),
    .inReady    (inReady),
    .outResult  (outResult),
    .outFlags   (outFlags),
    .outValid   (outValid),
    .outReady   (outReady),
    .nzcv       (nzcv),
    .illegalOp  (illegalOp),
    .dbgState   (dbgState)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operation sel; the selected slot carries res/flg, other slots
  // carry filler so a wrong select is visible.
  task automatic drive(input logic [SW-1:0] sel, input logic [31:0] res,
                       input logic [3:0] flg, input logic sf);
    opResults = {NUM_OPS{32'hDEAD_BEEF}};
    opFlags   = {NUM_OPS{4'hB}};
    if (int'(sel) < NUM_OPS) begin
      opResults[int'(sel)*N +: N] = res;
      opFlags[int'(sel)*4 +: 4]   = flg;
    end
    aluControl = sel;
    setFlags   = sf;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    inValid    = 1'b0;
    outReady   = 1'b0;
    drive(2'd0, 32'h0, 4'h0, 1'b0);

    // ---- reset state ----
    tick();
    tick();
    chk("rst_inready",  32'(inReady),   32'd0);
    chk("rst_outvalid", 32'(outValid),  32'd0);
    chk("rst_result",   outResult,      32'd0);
    chk("rst_flags",    32'(outFlags),  32'd0);
    chk("rst_nzcv",     32'(nzcv),      32'd0);
    chk("rst_illegal",  32'(illegalOp), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_inready",  32'(inReady),   32'd1);

    // ---- 1: single push, visible next cycle, pop commits flags ----
    drive(2'd1, 32'h0000_0005, 4'h2, 1'b1);
    inValid = 1'b1;
    #1;
    chk("t1_no_bypass", 32'(outValid), 32'd0);
    tick();
    inValid = 1'b0;
    chk("t1_outvalid", 32'(outValid), 32'd1);
    chk("t1_result",   outResult,     32'h0000_0005);
    chk("t1_flags",    32'(outFlags), 32'h2);
    chk("t1_state",    32'(dbgState), 32'd1);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("t1_nzcv",     32'(nzcv),     32'h2);
    chk("t1_empty",    32'(outValid), 32'd0);
    chk("t1_hold",     outResult,     32'h0000_0005);

    // ---- 2: fill while blocked, third offer (illegal select) rejected ----
    drive(2'd0, 32'h0000_0011, 4'h1, 1'b0);
    inValid = 1'b1;
    tick();
    chk("t2_ready1",   32'(inReady),  32'd1);
    drive(2'd2, 32'h0000_0022, 4'h8, 1'b0);
    tick();
    chk("t2_full",     32'(inReady),  32'd0);
    chk("t2_state",    32'(dbgState), 32'd2);
    drive(2'd3, 32'h0000_0033, 4'h3, 1'b1);
    tick();
    inValid = 1'b0;
    chk("t2_hold_head", outResult,     32'h0000_0011);
    chk("t2_no_illeg",  32'(illegalOp), 32'd0);
    outReady = 1'b1;
    tick();
    chk("t2_pop1_v",   32'(outValid), 32'd1);
    chk("t2_pop1_res", outResult,     32'h0000_0022);
    chk("t2_pop1_flg", 32'(outFlags), 32'h8);
    tick();
    outReady = 1'b0;
    chk("t2_drained",  32'(outValid), 32'd0);
    chk("t2_last",     outResult,     32'h0000_0022);
    chk("t2_nzcv",     32'(nzcv),     32'h2);

    // ---- 3: streaming push+pop in state ONE ----
    drive(2'd0, 32'h0000_0100, 4'h0, 1'b0);
    inValid = 1'b1;
    tick();
    exp_q.push_back(32'h0000_0100);
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'(i % NUM_OPS), 32'h0000_0200 + 32'(i), 4'h0, 1'b0);
      #1;
      chk("t3_ready",  32'(inReady),  32'd1);
      chk("t3_valid",  32'(outValid), 32'd1);
      chk("t3_order",  outResult,     exp_q[0]);
      exp_q.push_back(32'h0000_0200 + 32'(i));
      tick();
      void'(exp_q.pop_front());
    end
    inValid = 1'b0;
    chk("t3_last",     outResult,     32'h0000_0209);
    tick();
    outReady = 1'b0;
    chk("t3_empty",    32'(dbgState), 32'd0);

    // ---- 4: setFlags=0 entry leaves nzcv alone ----
    drive(2'd1, 32'h0000_0007, 4'h4, 1'b1);
    inValid = 1'b1;
    tick();
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    chk("t4_nzcv_set", 32'(nzcv), 32'h4);
    drive(2'd2, 32'h0000_0009, 4'hF, 1'b0);
    inValid  = 1'b1;
    outReady = 1'b0;
    tick();
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("t4_nzcv_keep", 32'(nzcv),     32'h4);
    chk("t4_popped",    32'(outValid), 32'd0);

    // ---- 5: illegal select, sticky flag ----
    drive(2'd3, 32'h1234_5678, 4'hA, 1'b1);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    chk("t5_result",   outResult,      32'd0);
    chk("t5_flags",    32'(outFlags),  32'h4);
    chk("t5_illegal",  32'(illegalOp), 32'd1);
    outReady = 1'b1;
    tick();
    drive(2'd0, 32'h0000_0055, 4'h1, 1'b0);
    inValid  = 1'b1;
    outReady = 1'b0;
    tick();
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("t5_legal_res", outResult,      32'h0000_0055);
    chk("t5_sticky",    32'(illegalOp), 32'd1);

    // ---- 6: reset with FULL FIFO while draining ----
    drive(2'd1, 32'h0000_0077, 4'hA, 1'b1);
    inValid = 1'b1;
    tick();
    tick();
    chk("t6_full",     32'(dbgState), 32'd2);
    reset    = 1'b1;
    outReady = 1'b1;
    #1;
    chk("t6_rdy_rst",  32'(inReady), 32'd0);
    tick();
    chk("t6_outvalid", 32'(outValid),  32'd0);
    chk("t6_nzcv",     32'(nzcv),      32'd0);
    chk("t6_illegal",  32'(illegalOp), 32'd0);
    chk("t6_result",   outResult,      32'd0);
    chk("t6_state",    32'(dbgState),  32'd0);
    reset    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    #1;
    chk("t6_rdy_rel",  32'(inReady), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
